// File: rtl/seq_counter_gen_pkg.sv
// Shared definitions for the sequence counter: mode encoding, depth limit and
// elaboration-time term generators used to build the lookup table.
package seq_counter_pkg;

  typedef enum logic [1:0] {
    SEQ_PRIME = 2'd0,
    SEQ_FIB   = 2'd1,
    SEQ_SQR   = 2'd2,
    SEQ_TRI   = 2'd3
  } seq_mode_e;

  localparam int MAX_DEPTH = 16;

  // The 16th prime is 53, so a search bound of 64 covers every legal depth.
  function automatic logic [15:0] prime_at(input int k);
    int cnt;
    bit isPrime;
    logic [15:0] res;
    cnt = 0;
    res = 16'd0;
    for (int n = 2; n < 64; n++) begin
      isPrime = 1'b1;
      for (int d = 2; d < n; d++) begin
        if (n % d == 0) isPrime = 1'b0;
      end
      if (isPrime) begin
        if (cnt == k) res = 16'(n);
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] fib_at(input int k);
    int a;
    int b;
    int t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return 16'(a);
  endfunction

  function automatic logic [15:0] square_at(input int k);
    return 16'(k * k);
  endfunction

  function automatic logic [15:0] tri_at(input int k);
    return 16'((k * (k + 1)) / 2);
  endfunction

  function automatic logic [15:0] term_at(input seq_mode_e m, input int k);
    case (m)
      SEQ_PRIME: return prime_at(k);
      SEQ_FIB:   return fib_at(k);
      SEQ_SQR:   return square_at(k);
      SEQ_TRI:   return tri_at(k);
      default:   return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_counter_gen_index_ctr.sv
// Up/down index counter with clamped load, clear and a registered wrap pulse.
// Also exposes the next-state index so the term lookup can be registered alongside.
module seq_index_ctr
  import seq_counter_pkg::*;
#(
  parameter int DEPTH = 11,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_loadIdx,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic             i_up,
  output logic [IDX_W-1:0] o_idx,
  output logic [IDX_W-1:0] o_nextIdx,
  output logic             o_wrap
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] r_idx;
  logic             r_wrap;
  logic [IDX_W-1:0] w_nextIdx;
  logic             w_wrap;

  // Load outranks clear, which outranks a step.
  always_comb begin
    w_nextIdx = r_idx;
    w_wrap    = 1'b0;
    if (i_load) begin
      w_nextIdx = (i_loadIdx > LAST) ? LAST : i_loadIdx;
    end else if (i_clear) begin
      w_nextIdx = '0;
    end else if (i_step) begin
      if (i_up) begin
        if (r_idx == LAST) begin
          w_nextIdx = '0;
          w_wrap    = 1'b1;
        end else begin
          w_nextIdx = r_idx + IDX_W'(1);
        end
      end else begin
        if (r_idx == '0) begin
          w_nextIdx = LAST;
          w_wrap    = 1'b1;
        end else begin
          w_nextIdx = r_idx - IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_nextIdx;
      r_wrap <= w_wrap;
    end
  end

  assign o_idx     = r_idx;
  assign o_nextIdx = w_nextIdx;
  assign o_wrap    = r_wrap;

endmodule

// File: rtl/seq_counter_gen.sv
// Sequence counter top: holds the active mode, resolves load/mode/step priority
// and registers the looked-up term together with its overflow flag.
module seq_counter_gen
  import seq_counter_pkg::*;
#(
  parameter int DEPTH = 11,
  parameter int OUT_W = 10,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             updown,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [OUT_W-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             ovf
);

  logic [15:0]      w_termTab [4][DEPTH];
  logic             w_ovfTab  [4][DEPTH];
  logic [1:0]       r_modeQ;
  logic [OUT_W-1:0] r_out;
  logic             r_ovf;
  logic             w_modeChange;
  logic [1:0]       w_nextMode;
  logic [IDX_W-1:0] w_nextIdx;

  // Table contents are constants folded at elaboration, so the lookup is a plain mux.
  for (genvar m = 0; m < 4; m++) begin : g_mode
    for (genvar k = 0; k < DEPTH; k++) begin : g_term
      assign w_termTab[m][k] = term_at(seq_mode_e'(m), k);
      assign w_ovfTab[m][k]  = ((32'(term_at(seq_mode_e'(m), k)) >> OUT_W) != 32'd0);
    end
  end

  assign w_modeChange = (mode != r_modeQ);
  assign w_nextMode   = (load || w_modeChange) ? mode : r_modeQ;

  seq_index_ctr #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_indexCtr (
    .clk       (clk),
    .reset     (reset),
    .i_load    (load),
    .i_loadIdx (load_idx),
    .i_clear   (w_modeChange),
    .i_step    (enable && !w_modeChange),
    .i_up      (updown),
    .o_idx     (idx),
    .o_nextIdx (w_nextIdx),
    .o_wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_modeQ <= SEQ_PRIME;
      r_out   <= OUT_W'(term_at(SEQ_PRIME, 0));
      r_ovf   <= 1'b0;
    end else begin
      r_modeQ <= w_nextMode;
      r_out   <= OUT_W'(w_termTab[w_nextMode][w_nextIdx]);
      r_ovf   <= w_ovfTab[w_nextMode][w_nextIdx];
    end
  end

  assign out = r_out;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_seq_counter_gen.sv
// Randomised and directed checks of two sequence counter configurations
// (DEPTH=11/OUT_W=10 and DEPTH=16/OUT_W=8) against a behavioural model.
module tb_seq_counter_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       updown;
  logic [1:0] mode;
  logic       load;
  logic [3:0] loadIdx;

  logic [9:0] outA;
  logic [3:0] idxA;
  logic       wrapA;
  logic       ovfA;
  logic [7:0] outB;
  logic [3:0] idxB;
  logic       wrapB;
  logic       ovfB;

  int numChecks = 0;
  int numFails  = 0;

  int termTab [4][16];
  int primes  [16] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53};

  int mIdxA, mModeA, mWrapA;
  int mIdxB, mModeB, mWrapB;
  logic [1:0] curMode;

  seq_counter_gen #(.DEPTH(11), .OUT_W(10)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .updown(updown), .mode(mode),
    .load(load), .load_idx(loadIdx), .out(outA), .idx(idxA), .wrap(wrapA), .ovf(ovfA)
  );

  seq_counter_gen #(.DEPTH(16), .OUT_W(8)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .updown(updown), .mode(mode),
    .load(load), .load_idx(loadIdx), .out(outB), .idx(idxB), .wrap(wrapB), .ovf(ovfB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed != expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Behavioural reading of one clock edge for a counter of the given depth.
  task automatic modelStep(input int depth, inout int mIdx, inout int mMode, output int mWrap);
    mWrap = 0;
    if (!reset) begin
      mIdx  = 0;
      mMode = 0;
    end else if (load) begin
      mIdx  = (int'(loadIdx) > depth - 1) ? depth - 1 : int'(loadIdx);
      mMode = int'(mode);
    end else if (int'(mode) != mMode) begin
      mMode = int'(mode);
      mIdx  = 0;
    end else if (enable) begin
      if (updown) begin
        if (mIdx == depth - 1) begin
          mIdx  = 0;
          mWrap = 1;
        end else mIdx = mIdx + 1;
      end else begin
        if (mIdx == 0) begin
          mIdx  = depth - 1;
          mWrap = 1;
        end else mIdx = mIdx - 1;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("outA",  int'(outA),  termTab[mModeA][mIdxA] % 1024);
    checkOutput("idxA",  int'(idxA),  mIdxA);
    checkOutput("wrapA", int'(wrapA), mWrapA);
    checkOutput("ovfA",  int'(ovfA),  (termTab[mModeA][mIdxA] >= 1024) ? 1 : 0);
    checkOutput("outB",  int'(outB),  termTab[mModeB][mIdxB] % 256);
    checkOutput("idxB",  int'(idxB),  mIdxB);
    checkOutput("wrapB", int'(wrapB), mWrapB);
    checkOutput("ovfB",  int'(ovfB),  (termTab[mModeB][mIdxB] >= 256) ? 1 : 0);
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic ud,
                               input logic [1:0] md, input logic ld, input logic [3:0] li);
    reset   = rst;
    enable  = en;
    updown  = ud;
    mode    = md;
    load    = ld;
    loadIdx = li;
    @(posedge clk);
    modelStep(11, mIdxA, mModeA, mWrapA);
    modelStep(16, mIdxB, mModeB, mWrapB);
    #1;
    compareAll();
  endtask

  initial begin
    int fib [16];
    fib[0] = 0;
    fib[1] = 1;
    for (int k = 2; k < 16; k++) fib[k] = fib[k-1] + fib[k-2];
    for (int k = 0; k < 16; k++) begin
      termTab[0][k] = primes[k];
      termTab[1][k] = fib[k];
      termTab[2][k] = k * k;
      termTab[3][k] = (k * (k + 1)) / 2;
    end
    mIdxA = 0; mModeA = 0; mWrapA = 0;
    mIdxB = 0; mModeB = 0; mWrapB = 0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0);
    checkOutput("rstOut",  int'(outA),  2);
    checkOutput("rstIdx",  int'(idxA),  0);
    checkOutput("rstWrap", int'(wrapA), 0);

    // Prime walk upward through the full DEPTH=11 sequence
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'd0);
    checkOutput("primeLast", int'(outA), 31);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'd0);
    checkOutput("primeWrapOut", int'(outA),  2);
    checkOutput("primeWrap",    int'(wrapA), 1);

    // Fibonacci, downward wrap from index 0
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'd0);
    checkOutput("fibClear", int'(outA), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0);
    checkOutput("fibDownWrapOut", int'(outA),  55);
    checkOutput("fibDownWrap",    int'(wrapA), 1);
    checkOutput("fib15B",         int'(outB),  98);
    checkOutput("fib15OvfB",      int'(ovfB),  1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0);
    checkOutput("fibDownOut", int'(outA),  34);
    checkOutput("fibDownNoWrap", int'(wrapA), 0);

    // Mode change discards a simultaneous step
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd4);
    checkOutput("prime4", int'(outA), 11);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'd0);
    checkOutput("sqrClearOut", int'(outA), 0);
    checkOutput("sqrClearIdx", int'(idxA), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'd0);
    checkOutput("sqrStep", int'(outA), 1);

    // Load with clamp wins over a simultaneous mode change
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 4'd13);
    checkOutput("loadClampIdx", int'(idxA), 10);
    checkOutput("loadClampOut", int'(outA), 55);
    checkOutput("loadTriB",     int'(outB), 91);

    // Overflow boundary on the 8-bit instance
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 4'd15);
    checkOutput("ovf15Out", int'(outB), 98);
    checkOutput("ovf15",    int'(ovfB), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0);
    checkOutput("ovf14Out", int'(outB), 121);
    checkOutput("ovf14",    int'(ovfB), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0);
    checkOutput("ovf13Out", int'(outB), 233);
    checkOutput("ovf13",    int'(ovfB), 0);

    // Reset mid-count overrides load, enable and mode
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'd0);
    checkOutput("preRstIdx", int'(idxA), 7);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'd5);
    checkOutput("midRstOut", int'(outA), 2);
    checkOutput("midRstIdx", int'(idxA), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'd9);
    checkOutput("holdOut", int'(outA), 2);

    // Randomised traffic
    curMode = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) curMode = 2'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 31) != 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    curMode,
                    ($urandom_range(0, 7) == 0),
                    4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
